z80_int_ctrl: RTL and testbench

Z80_INT_CTRL -- requirements
Module: z80_int_ctrl

---
 rtl/z80_int_pkg.sv | 36 +++
 rtl/z80_nmi_pulse.sv | 53 +++++
 rtl/z80_int_ctrl.sv | 172 +++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/z80_int_pkg.sv
// Shared types, config register map and vector helpers for the Z80 interrupt controller.
package z80_int_pkg;

    // Maskable-interrupt handshake states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACK    = 2'd2,
        ST_HOLD   = 2'd3
    } int_state_e;

    // Config register select values
    localparam logic [1:0] CFG_MASK   = 2'd0;
    localparam logic [1:0] CFG_VBASE  = 2'd1;
    localparam logic [1:0] CFG_ENABLE = 2'd2;
    localparam logic [1:0] CFG_NONE   = 2'd3;

    // IM2 vector byte: table base nibble, source index, always-even LSB
    function automatic logic [7:0] make_vector(input logic [3:0] vbase_hi,
                                               input logic [2:0] src);
        return {vbase_hi, src, 1'b0};
    endfunction

    // Index of the lowest set bit (bit 0 has highest priority); 0 when empty
    function automatic logic [2:0] lowest_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/z80_nmi_pulse.sv
// NMI request edge detector and fixed-width low pulse generator.
module z80_nmi_pulse
    import z80_int_pkg::*;
#(
    parameter int unsigned NMI_PULSE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic nmi_req,
    output logic nnmi
);

    localparam logic [3:0] PULSE_LOAD = 4'(NMI_PULSE);

    logic       nmi_req_q,  nmi_req_d;
    logic       nmi_prev_q, nmi_prev_d;
    logic [3:0] cnt_q,      cnt_d;
    logic       nnmi_q,     nnmi_d;
    logic       edge_s;

    // Edge detect on the registered request; a running pulse ignores new edges
    always_comb begin
        nmi_req_d  = nmi_req;
        nmi_prev_d = nmi_req_q;
        edge_s     = nmi_req_q & ~nmi_prev_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (edge_s) begin
            cnt_d = PULSE_LOAD;
        end else begin
            cnt_d = 4'd0;
        end
        nnmi_d = (cnt_d == 4'd0);
    end

    // State and registered output, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_req_q  <= 1'b0;
            nmi_prev_q <= 1'b0;
            cnt_q      <= 4'd0;
            nnmi_q     <= 1'b1;
        end else begin
            nmi_req_q  <= nmi_req_d;
            nmi_prev_q <= nmi_prev_d;
            cnt_q      <= cnt_d;
            nnmi_q     <= nnmi_d;
        end
    end

    assign nnmi = nnmi_q;

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 IM2 interrupt controller: 8 prioritised level sources plus an NMI pulser.
module z80_int_ctrl
    import z80_int_pkg::*;
#(
    parameter int unsigned NMI_PULSE = 4,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic       CPUCLK,
    input  logic       RESET,
    input  logic       nM1,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic [7:0] irq_req,
    input  logic       nmi_req,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic       nINT,
    output logic       nNMI,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic [7:0] irq_ack
);

    localparam logic [2:0] HOLD_LOAD = 3'(HOLDOFF - 1);

    int_state_e state_q,    state_d;
    logic [7:0] mask_q,     mask_d;
    logic [3:0] vbase_q,    vbase_d;
    logic       enable_q,   enable_d;
    logic [2:0] winner_q,   winner_d;
    logic [2:0] hold_cnt_q, hold_cnt_d;
    logic       nint_q,     nint_d;
    logic       d_oe_q,     d_oe_d;
    logic [7:0] d_out_q,    d_out_d;
    logic [7:0] irq_ack_q,  irq_ack_d;
    logic [7:0] pending_s;
    logic       ack_s;

    // Config register writes; the unmapped address is silently dropped
    always_comb begin
        mask_d   = mask_q;
        vbase_d  = vbase_q;
        enable_d = enable_q;
        if (cfg_we) begin
            case (cfg_addr)
                CFG_MASK:   mask_d   = cfg_wdata;
                CFG_VBASE:  vbase_d  = cfg_wdata[7:4];
                CFG_ENABLE: enable_d = cfg_wdata[0];
                CFG_NONE:   mask_d   = mask_q;
                default:    mask_d   = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end
    end

    assign pending_s = irq_req & mask_q & {8{enable_q}};
    assign ack_s     = ~nM1 & ~nIORQ;

    // Handshake FSM; ack wins over a simultaneous withdraw and keeps the last winner
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        hold_cnt_d = hold_cnt_q;
        irq_ack_d  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (pending_s != 8'h00) begin
                    winner_d = lowest_index(pending_s);
                    state_d  = ST_ASSERT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (pending_s != 8'h00) begin
                    winner_d = lowest_index(pending_s);
                end else begin
                    winner_d = winner_q;
                end
                if (ack_s) begin
                    state_d = ST_ACK;
                end else if (pending_s == 8'h00) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ACK: begin
                if (nIORQ) begin
                    irq_ack_d  = 8'h01 << winner_q;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state; the vector is latched on ACK entry
    always_comb begin
        nint_d = (state_d != ST_ASSERT);
        d_oe_d = (state_d == ST_ACK);
        if (state_d == ST_ACK) begin
            if (state_q == ST_ACK) begin
                d_out_d = d_out_q;
            end else begin
                d_out_d = make_vector(vbase_q, winner_d);
            end
        end else begin
            d_out_d = 8'h00;
        end
    end

    // State, config and output registers with synchronous reset
    always_ff @(posedge CPUCLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            mask_q     <= 8'h00;
            vbase_q    <= 4'h0;
            enable_q   <= 1'b0;
            winner_q   <= 3'd0;
            hold_cnt_q <= 3'd0;
            nint_q     <= 1'b1;
            d_oe_q     <= 1'b0;
            d_out_q    <= 8'h00;
            irq_ack_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            vbase_q    <= vbase_d;
            enable_q   <= enable_d;
            winner_q   <= winner_d;
            hold_cnt_q <= hold_cnt_d;
            nint_q     <= nint_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    z80_nmi_pulse #(
        .NMI_PULSE (NMI_PULSE)
    ) u_nmi (
        .clk     (CPUCLK),
        .rst     (RESET),
        .nmi_req (nmi_req),
        .nnmi    (nNMI)
    );

    assign nINT    = nint_q;
    assign d_oe    = d_oe_q;
    assign d_out   = d_out_q;
    assign irq_ack = irq_ack_q;

    // The CPU must not be reading memory while the vector is on the bus
    a_nrd_high_in_ack : assert property (@(posedge CPUCLK) disable iff (RESET)
        (state_q == ST_ACK) |-> nRD);

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed, table-driven bench for z80_int_ctrl (defaults NMI_PULSE=4, HOLDOFF=2).
module tb_z80_int_ctrl;

    logic       CPUCLK;
    logic       RESET;
    logic       nM1, nIORQ, nRD;
    logic [7:0] irq_req;
    logic       nmi_req;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       nINT, nNMI, d_oe;
    logic [7:0] d_out, irq_ack;

    int errors = 0;
    int checks = 0;

    z80_int_ctrl #(.NMI_PULSE(4), .HOLDOFF(2)) dut (
        .CPUCLK    (CPUCLK),
        .RESET     (RESET),
        .nM1       (nM1),
        .nIORQ     (nIORQ),
        .nRD       (nRD),
        .irq_req   (irq_req),
        .nmi_req   (nmi_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .nINT      (nINT),
        .nNMI      (nNMI),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .irq_ack   (irq_ack)
    );

    initial CPUCLK = 1'b0;
    always #5 CPUCLK = ~CPUCLK;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       nm1;
        logic       niorq;
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       exp_nint;
        logic       exp_doe;
        logic [7:0] exp_dout;
        logic [7:0] exp_ack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [7:0] irq,
                                input logic nm1, input logic niorq,
                                input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                                input logic exp_nint, input logic exp_doe,
                                input logic [7:0] exp_dout, input logic [7:0] exp_ack);
        vec_t v;
        v.rst = rst; v.irq = irq; v.nm1 = nm1; v.niorq = niorq;
        v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_nint = exp_nint; v.exp_doe = exp_doe;
        v.exp_dout = exp_dout; v.exp_ack = exp_ack;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CPUCLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1;
        irq_req = 8'h00; nmi_req = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;

        //            rst  irq    nM1   nIORQ we    addr  wdata   nINT  doe   dout   ack
        vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // 0 reset
        vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00)); // mask
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00)); // vbase
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00)); // enable
        vecs.push_back(mk(1'b0, 8'h0C, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // 5 assert
        vecs.push_back(mk(1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA4, 8'h00)); // ack
        vecs.push_back(mk(1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA4, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h04)); // leave ack
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // 10
        vecs.push_back(mk(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // withdraw
        vecs.push_back(mk(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // 15 simult
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA2, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h02));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // 20 holdoff
        vecs.push_back(mk(1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA8, 8'h00));
        vecs.push_back(mk(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h10));
        vecs.push_back(mk(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // 25
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // disable in ASSERT
        vecs.push_back(mk(1'b0, 8'h08, 1'b1, 1'b1, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h08, 1'b1, 1'b1, 1'b1, 2'd2, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00)); // 30
        vecs.push_back(mk(1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // mask=0
        vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // 35
        vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 2'd0, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hAE, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h80));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // 40
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00)); // addr3 ignored
        vecs.push_back(mk(1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hAE, 8'h00));
        vecs.push_back(mk(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 1'b1, 8'hAE, 8'h00)); // disable in ACK
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h80)); // 45
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00)); // 50
        vecs.push_back(mk(1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hAE, 8'h00));
        vecs.push_back(mk(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // reset in ACK
        vecs.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00)); // 55

        for (int i = 0; i < vecs.size(); i++) begin
            RESET     = vecs[i].rst;
            irq_req   = vecs[i].irq;
            nM1       = vecs[i].nm1;
            nIORQ     = vecs[i].niorq;
            cfg_we    = vecs[i].we;
            cfg_addr  = vecs[i].addr;
            cfg_wdata = vecs[i].wdata;
            step();
            chk("nINT",    i, {7'd0, nINT},  {7'd0, vecs[i].exp_nint});
            chk("nNMI",    i, {7'd0, nNMI},  8'h01);
            chk("d_oe",    i, {7'd0, d_oe},  {7'd0, vecs[i].exp_doe});
            chk("d_out",   i, d_out,         vecs[i].exp_dout);
            chk("irq_ack", i, irq_ack,       vecs[i].exp_ack);
        end

        // NMI: rises at t0, again at t0+2 during the pulse; one 4-cycle pulse only
        RESET = 1'b0; irq_req = 8'h00; nM1 = 1'b1; nIORQ = 1'b1; cfg_we = 1'b0;
        begin
            logic [7:0] nmi_in;
            logic [7:0] nmi_exp;
            nmi_in  = 8'b0000_0101;
            nmi_exp = 8'b1110_0001;
            for (int k = 0; k < 8; k++) begin
                nmi_req = nmi_in[k];
                step();
                chk("nmi_pulse", k, {7'd0, nNMI}, {7'd0, nmi_exp[k]});
                chk("nmi_nint",  k, {7'd0, nINT}, 8'h01);
            end
        end

        // Reset in the middle of an NMI pulse ends it at once with no residue
        nmi_req = 1'b1; step();
        nmi_req = 1'b0; step();
        chk("nmi_mid_low", 0, {7'd0, nNMI}, 8'h00);
        RESET = 1'b1; step();
        chk("nmi_rst", 0, {7'd0, nNMI}, 8'h01);
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("nmi_after_rst", k, {7'd0, nNMI}, 8'h01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
